// File: rtl/pc_pkg.sv
// Shared command encoding for the program counter with return-address stack.
// The decode function fixes which command wins when several strobes are high.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET
    } pc_cmd_e;

    // Priority: load > call > ret > inc; nothing asserted means hold.
    function automatic pc_cmd_e pc_decode(
        input logic load,
        input logic call,
        input logic ret,
        input logic inc
    );
        pc_cmd_e cmd;
        if (load)
            cmd = CMD_LOAD;
        else if (call)
            cmd = CMD_CALL;
        else if (ret)
            cmd = CMD_RET;
        else if (inc)
            cmd = CMD_INC;
        else
            cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses. Top of stack is read combinationally so a pop
// can land in the PC on the same edge that retires the entry.
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    depth_reg;
    logic [DW-1:0]    depth_next;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (depth_reg == DW'(DEPTH));
    assign empty   = (depth_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Indices are only used when the matching guard holds, so truncation is safe.
    assign wr_idx = AW'(depth_reg);
    assign rd_idx = AW'(depth_reg - DW'(1));

    always_comb begin
        depth_next = depth_reg;
        if (do_push)
            depth_next = depth_reg + DW'(1);
        else if (do_pop)
            depth_next = depth_reg - DW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            depth_reg <= '0;
        else
            depth_reg <= depth_next;
    end

    // Storage has no reset; contents beyond the pointer are don't-care.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= wdata;
    end

    assign rdata = mem[rd_idx];
    assign depth = depth_reg;

endmodule

// File: rtl/pc_call_stack.sv
// Fetch-stage program counter with configurable step and a hardware
// return-address stack; sticky overflow/underflow flags record misuse.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] seq_pc;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_rdata;
    logic             stk_full;
    logic             stk_empty;

    assign cmd    = pc_decode(load, call, ret, inc);
    assign seq_pc = pc_reg + WIDTH'(STEP);

    assign stk_push = (cmd == CMD_CALL) && !stk_full;
    assign stk_pop  = (cmd == CMD_RET) && !stk_empty;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stk_push),
        .pop     (stk_pop),
        .wdata   (seq_pc),
        .rdata   (stk_rdata),
        .depth   (depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // Clear is applied first so a same-cycle error event leaves the flag set.
    always_comb begin
        pc_next        = pc_reg;
        overflow_next  = clr_err ? 1'b0 : overflow_reg;
        underflow_next = clr_err ? 1'b0 : underflow_reg;
        unique case (cmd)
            CMD_LOAD: pc_next = in;
            CMD_CALL: begin
                pc_next = in;
                if (stk_full)
                    overflow_next = 1'b1;
            end
            CMD_RET: begin
                if (stk_empty)
                    underflow_next = 1'b1;
                else
                    pc_next = stk_rdata;
            end
            CMD_INC:  pc_next = seq_pc;
            default:  pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign out       = pc_reg;
    assign empty     = stk_empty;
    assign full      = stk_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule
